// File: rtl/mips_pkg.sv
// Shared MIPS core types: PC source select, sequencer states, reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    INCREMENT = 2'b00,
    BRANCH    = 2'b01,
    JUMP      = 2'b10,
    JR        = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SLOT   = 2'b01,
    HALTED = 2'b10
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target: decides whether the current
// instruction redirects the PC and where the redirect lands.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       pc_sel,
  input  logic             is_true,
  input  logic [WIDTH-1:0] extended_imm,
  input  logic [25:0]      j_addr,
  input  logic [WIDTH-1:0] reg_data_a,
  output logic [WIDTH-1:0] target,
  output logic             taken,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc + WIDTH'(4);

  // Select the redirect target for the decoded control-transfer type.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    target     = pc_plus4;
    taken      = 1'b0;
    misaligned = 1'b0;
    case (pc_sel_t'(pc_sel))
      BRANCH: begin
        taken  = is_true;
        target = pc_plus4 + (extended_imm << 2);
      end
      JUMP: begin
        taken  = 1'b1;
        target = {pc_plus4[WIDTH-1:28], j_addr, 2'b00};
      end
      JR: begin
        taken      = 1'b1;
        target     = {reg_data_a[WIDTH-1:2], 2'b00};
        misaligned = |reg_data_a[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with MIPS branch-delay-slot semantics, memory
// stall hold, and halt detection on a redirect to HALT_ADDR.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
  parameter logic [WIDTH-1:0] HALT_ADDR    = '0,
  parameter int               LINK_OFFSET  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic             is_true,
  input  logic [WIDTH-1:0] extended_imm,
  input  logic [25:0]      j_addr,
  input  logic [WIDTH-1:0] reg_data_a,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link_pc,
  output logic             in_delay_slot,
  output logic             active,
  output logic             jr_misaligned
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             jr_mis_q, jr_mis_d;

  logic [WIDTH-1:0] calc_target;
  logic             calc_taken;
  logic             calc_misaligned;

  pc_target_calc #(.WIDTH(WIDTH)) u_target_calc (
    .pc           (pc_q),
    .pc_sel       (pc_sel),
    .is_true      (is_true),
    .extended_imm (extended_imm),
    .j_addr       (j_addr),
    .reg_data_a   (reg_data_a),
    .target       (calc_target),
    .taken        (calc_taken),
    .misaligned   (calc_misaligned)
  );

  // Next-state logic: a taken transfer in RUN arms the delay slot; SLOT
  // applies the stored target or halts; HALTED holds until reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    jr_mis_d  = 1'b0;
    if (!stall) begin
      case (state_q)
        RUN: begin
          pc_d = pc_q + WIDTH'(4);
          if (calc_taken) begin
            pending_d = calc_target;
            state_d   = SLOT;
            jr_mis_d  = calc_misaligned;
          end
        end
        SLOT: begin
          pc_d = pending_q;
          if (pending_q == HALT_ADDR) state_d = HALTED;
          else                        state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  // State registers; stall is folded into the next-state values above.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      jr_mis_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      jr_mis_q  <= jr_mis_d;
    end
  end

  assign pc            = pc_q;
  assign link_pc       = pc_q + WIDTH'(LINK_OFFSET);
  assign in_delay_slot = (state_q == SLOT);
  assign active        = (state_q != HALTED);
  assign jr_misaligned = jr_mis_q & ~stall;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter unit for the multicycle/pipelined MIPS core, successor to the combinational next-PC selector. Owns the PC register, implements MIPS branch-delay-slot semantics (target applied one instruction after the branch), honours a memory stall, and detects the halt condition (jump to HALT_ADDR) to drop `active`. Sits between the decoder/ALU (control, condition) and instruction memory (address).

Parameters:
WIDTH, 32, PC/data width (instruction fields remain MIPS-fixed: j_addr 26 bits)
RESET_VECTOR, 32'hBFC00000, PC value after reset
HALT_ADDR, 32'h00000000, target address that halts the CPU once its delay slot completes
LINK_OFFSET, 8, offset added to PC for link register value

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold all state this cycle (memory wait)
pc_sel  input  2  00 INCREMENT, 01 BRANCH, 10 JUMP, 11 JR (from decoder)
is_true  input  1  branch condition from ALU
extended_imm  input  WIDTH  sign-extended 16-bit immediate
j_addr  input  26  instruction[25:0]
reg_data_a  input  WIDTH  rs value for JR/JALR
pc  output  WIDTH  current instruction address
link_pc  output  WIDTH  pc + LINK_OFFSET (combinational)
in_delay_slot  output  1  high while the current instruction is a delay slot
active  output  1  high until halt
jr_misaligned  output  1  one-cycle pulse: JR target had nonzero [1:0]

Behaviour:
- Reset (async, any state): pc=RESET_VECTOR, state=RUN, pending_target=0, in_delay_slot=0, active=1, jr_misaligned=0.
- States: RUN, SLOT, HALTED. Updates only on rising clk with stall=0; stall=1 holds pc, state, pending_target, flags (jr_misaligned forced 0 during stall).
- RUN:
  - pc_sel=INCREMENT, or BRANCH with is_true=0: pc<=pc+4, stay RUN.
  - BRANCH & is_true: pending_target<=pc+4+(extended_imm<<2) (mod 2^WIDTH).
  - JUMP: pending_target<={(pc+4)[WIDTH-1:28], j_addr, 2'b00}.
  - JR: pending_target<={reg_data_a[WIDTH-1:2],2'b00}; jr_misaligned<=|reg_data_a[1:0] for one cycle.
  - Any taken case: pc<=pc+4, state->SLOT, in_delay_slot<=1.
- SLOT (delay-slot instruction executing):
  - Control inputs ignored (branch in delay slot is architecturally undefined; defined here as no effect).
  - If pending_target==HALT_ADDR: state->HALTED, active<=0, pc<=HALT_ADDR.
  - Else pc<=pending_target, state->RUN, in_delay_slot<=0.
- HALTED: pc, outputs frozen; only reset exits. active=0.
- link_pc = pc+LINK_OFFSET, wraps mod 2^WIDTH; valid in all states.
- pc+4 wrap at 2^WIDTH-4 -> 0 is legal and NOT a halt (halt only via taken-control target).
- Reset asserted mid-SLOT discards pending_target.
- Stall during SLOT delays the redirect; target still applied on first unstalled edge.

Decomposition:
- Shared package mips_pkg: pc_sel_t enum (INCREMENT/BRANCH/JUMP/JR, 2 bits), pc_state_t (RUN/SLOT/HALTED), constant RESET_VECTOR_DEFAULT.
- Sub-module pc_target_calc (combinational target computation from pc, pc_sel, immediates, reg_data_a; outputs target, taken, misaligned); pc_sequencer holds the FSM and registers.

Test Plan:
- Reset then 3 unstalled cycles, pc_sel=00 -> pc BFC00000, BFC00004, BFC00008, BFC0000C; active=1; link_pc=pc+8.
- At pc=BFC00010, BRANCH, is_true=1, imm=32'hFFFFFFFE -> next pc BFC00014 (in_delay_slot=1), then BFC0000C; is_true=0 -> BFC00014 then BFC00018.
- At pc=BFC00020, JUMP, j_addr=26'h0000100 -> pc BFC00024 then B0000400.
- JR with reg_data_a=0 -> pc advances to delay slot, next edge active=0, pc=0, state HALTED; further control inputs ignored until reset.
- JR reg_data_a=32'h00400006 -> jr_misaligned pulses 1 cycle, target 00400004; hold stall=1 for 3 cycles in SLOT -> pc unchanged, then 00400004.
- Assert reset asynchronously mid-SLOT (between edges) -> pc=BFC00000 immediately, in_delay_slot=0, pending target not applied.
